esm_issue_buffer: RTL and testbench

Slot-based instruction buffer on the consumer side of the ESM dependency analyser. It allocates a buffer slot to each incoming instruction and drives that slot's index to the analyser. It accepts the analyser's ready_index notifications, issues ready instructions to the execution stage over a valid/ready handshake, and frees each slot on completion. It sits between fetch/decode and the execution units, alongside ESM_core_IDA.

---
 rtl/esm_pkg.sv | 16 +
 rtl/esm_prio_enc.sv | 20 ++
 rtl/esm_issue_buffer.sv | 93 +++++++++
 tb/tb_esm_issue_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared slot-state encoding for the ESM issue buffer and dependency analyser.
package esm_pkg;

  localparam logic [1:0] SC_FREE    = 2'd0;
  localparam logic [1:0] SC_WAITING = 2'd1;
  localparam logic [1:0] SC_READY   = 2'd2;
  localparam logic [1:0] SC_ISSUED  = 2'd3;

  typedef enum logic [1:0] {
    FREE    = SC_FREE,
    WAITING = SC_WAITING,
    READY   = SC_READY,
    ISSUED  = SC_ISSUED
  } slot_state_t;

endpackage

// File: rtl/esm_prio_enc.sv
// Lowest-set-bit priority encoder with an any-set flag.
module esm_prio_enc #(
  parameter int bs = 16,
  localparam int bs_bits = $clog2(bs)
) (
  input  logic [bs-1:0]      vec,
  output logic [bs_bits-1:0] idx,
  output logic               any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Walk downward so the lowest set bit is the last one written.
    for (int i = bs - 1; i >= 0; i--) begin
      if (vec[i]) idx = bs_bits'(i);
    end
  end

endmodule

// File: rtl/esm_issue_buffer.sv
// Slot-based instruction buffer: allocates slots, tracks analyser readiness,
// issues ready instructions over valid/ready and frees slots on completion.
module esm_issue_buffer
  import esm_pkg::*;
#(
  parameter int Instr_word_size = 32,
  parameter int bs = 16,
  localparam int bs_bits = $clog2(bs)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Instr_word_size-1:0] in_instr,
  output logic [bs_bits-1:0]         alloc_index,
  input  logic                       rdy_valid,
  input  logic [bs_bits-1:0]         rdy_index,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [Instr_word_size-1:0] issue_instr,
  output logic [bs_bits-1:0]         issue_index,
  input  logic                       cmpl_valid,
  input  logic [bs_bits-1:0]         cmpl_index,
  output logic [bs_bits:0]           occupancy,
  output logic                       err
);

  slot_state_t                state [bs];
  logic [Instr_word_size-1:0] mem   [bs];

  logic [bs-1:0]      free_vec, ready_vec;
  logic [bs_bits-1:0] sel_index;
  logic               sel_any;

  for (genvar i = 0; i < bs; i++) begin : g_vec
    assign free_vec[i]  = (state[i] == FREE);
    assign ready_vec[i] = (state[i] == READY);
  end

  esm_prio_enc #(.bs(bs)) u_alloc_enc (
    .vec (free_vec),
    .idx (alloc_index),
    .any (in_ready)
  );

  esm_prio_enc #(.bs(bs)) u_issue_enc (
    .vec (ready_vec),
    .idx (sel_index),
    .any (sel_any)
  );

  logic alloc, rdy_ok, cmpl_ok, load_en;

  // The slot on alloc_index is FREE, so the WAITING test already rejects it;
  // a slot still held in the issue register cannot complete yet.
  assign alloc   = in_valid && in_ready;
  assign rdy_ok  = rdy_valid && (state[rdy_index] == WAITING);
  assign cmpl_ok = cmpl_valid && (state[cmpl_index] == ISSUED) &&
                   !(issue_valid && (issue_index == cmpl_index));
  assign load_en = !issue_valid || issue_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < bs; i++) state[i] <= FREE;
      issue_valid <= 1'b0;
      issue_instr <= '0;
      issue_index <= '0;
      occupancy   <= '0;
      err         <= 1'b0;
    end else begin
      // alloc, rdy, cmpl and issue select each act on a different state class,
      // so they never target the same slot in one cycle.
      if (alloc)   state[alloc_index] <= WAITING;
      if (rdy_ok)  state[rdy_index]   <= READY;
      if (cmpl_ok) state[cmpl_index]  <= FREE;
      if (load_en) begin
        issue_valid <= sel_any;
        if (sel_any) begin
          state[sel_index] <= ISSUED;
          issue_instr      <= mem[sel_index];
          issue_index      <= sel_index;
        end
      end
      occupancy <= occupancy + (bs_bits+1)'(alloc) - (bs_bits+1)'(cmpl_ok);
      if ((rdy_valid && !rdy_ok) || (cmpl_valid && !cmpl_ok)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) mem[alloc_index] <= in_instr;
  end

endmodule

// File: tb/tb_esm_issue_buffer.sv
// Directed bench for esm_issue_buffer: expected issues go into a scoreboard
// queue, a negedge monitor pops and compares on every issue handshake.
module tb_esm_issue_buffer;

  localparam int W  = 32;
  localparam int BS = 16;
  localparam int BB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_instr;
  logic [BB-1:0] alloc_index;
  logic          rdy_valid;
  logic [BB-1:0] rdy_index;
  logic          issue_valid, issue_ready;
  logic [W-1:0]  issue_instr;
  logic [BB-1:0] issue_index;
  logic          cmpl_valid;
  logic [BB-1:0] cmpl_index;
  logic [BB:0]   occupancy;
  logic          err;

  esm_issue_buffer #(.Instr_word_size(W), .bs(BS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alloc_index(alloc_index),
    .rdy_valid(rdy_valid), .rdy_index(rdy_index),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_index(issue_index),
    .cmpl_valid(cmpl_valid), .cmpl_index(cmpl_index),
    .occupancy(occupancy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  instr;
    logic [BB-1:0] index;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] instr, input logic [BB-1:0] idx);
    exp_t e;
    e.instr = instr;
    e.index = idx;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with valid&&ready is exactly one issue handshake.
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        check("issue_unexpected", 64'(issue_index), 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_instr", 64'(issue_instr), 64'(e.instr));
        check("issue_index", 64'(issue_index), 64'(e.index));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0;
    rdy_valid = 1'b0; rdy_index = '0; issue_ready = 1'b0;
    cmpl_valid = 1'b0; cmpl_index = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state and first allocation
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_alloc", 64'(alloc_index), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_issue_instr", 64'(issue_instr), 64'd0);
    in_valid = 1'b1; in_instr = 32'h00A00093;
    check("first_alloc", 64'(alloc_index), 64'd0);
    tick();
    in_valid = 1'b0;
    check("second_alloc", 64'(alloc_index), 64'd1);
    check("occ_1", 64'(occupancy), 64'd1);

    // Fill to full, then hold in_valid with nothing free
    for (int i = 1; i < BS; i++) begin
      in_valid = 1'b1; in_instr = 32'h1000 + i;
      check("fill_alloc", 64'(alloc_index), 64'(i));
      tick();
    end
    in_instr = 32'hDEADBEEF;
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_occ", 64'(occupancy), 64'd16);
    tick(); tick();
    check("full_hold_occ", 64'(occupancy), 64'd16);
    check("full_hold_ready", 64'(in_ready), 64'd0);
    check("full_hold_err", 64'(err), 64'd0);
    in_valid = 1'b0;

    // Out-of-order readiness, stalled issue, then back-to-back drain
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = 32'hA0 + i; tick();
    end
    in_valid = 1'b0;
    rdy_valid = 1'b1; rdy_index = 4'd2; push(32'hA2, 4'd2);
    tick();
    check("lat_not_yet", 64'(issue_valid), 64'd0);
    rdy_index = 4'd0; push(32'hA0, 4'd0);
    tick();
    rdy_valid = 1'b0;
    check("issue_first_valid", 64'(issue_valid), 64'd1);
    check("issue_first_idx", 64'(issue_index), 64'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 64'(issue_valid), 64'd1);
      check("stall_idx", 64'(issue_index), 64'd2);
      check("stall_instr", 64'(issue_instr), 64'hA2);
    end
    issue_ready = 1'b1;
    tick();
    check("b2b_valid", 64'(issue_valid), 64'd1);
    check("b2b_idx", 64'(issue_index), 64'd0);
    tick();
    check("drained", 64'(issue_valid), 64'd0);

    // Completion + allocation in the same cycle: the freed slot is not reused yet
    in_valid = 1'b1; in_instr = 32'hA3; tick(); in_valid = 1'b0;
    check("alloc_after_3", 64'(alloc_index), 64'd4);
    rdy_valid = 1'b1; rdy_index = 4'd3; push(32'hA3, 4'd3);
    tick();
    rdy_valid = 1'b0;
    tick();
    check("issue3_idx", 64'(issue_index), 64'd3);
    tick();
    check("issue3_done", 64'(issue_valid), 64'd0);
    cmpl_valid = 1'b1; cmpl_index = 4'd3;
    in_valid = 1'b1; in_instr = 32'hA4;
    check("cmpl_alloc_idx", 64'(alloc_index), 64'd4);
    check("cmpl_alloc_occ_before", 64'(occupancy), 64'd4);
    tick();
    cmpl_valid = 1'b0; in_valid = 1'b0;
    check("freed_alloc_idx", 64'(alloc_index), 64'd3);
    check("cmpl_alloc_occ_after", 64'(occupancy), 64'd4);
    check("cmpl_alloc_err", 64'(err), 64'd0);

    // Protocol errors: rdy for FREE slot 7, cmpl for WAITING slot 1
    rdy_valid = 1'b1; rdy_index = 4'd7;
    cmpl_valid = 1'b1; cmpl_index = 4'd1;
    tick();
    rdy_valid = 1'b0; cmpl_valid = 1'b0;
    check("err_set", 64'(err), 64'd1);
    check("err_occ", 64'(occupancy), 64'd4);
    check("err_alloc", 64'(alloc_index), 64'd3);
    check("err_no_issue", 64'(issue_valid), 64'd0);
    // Slot 1 must still be WAITING: it becomes ready and issues normally
    rdy_valid = 1'b1; rdy_index = 4'd1; push(32'hA1, 4'd1);
    tick();
    rdy_valid = 1'b0;
    tick();
    check("slot1_issue_idx", 64'(issue_index), 64'd1);
    tick();
    cmpl_valid = 1'b1; cmpl_index = 4'd0; tick();
    cmpl_index = 4'd1; tick();
    cmpl_valid = 1'b0;
    check("occ_after_cmpl", 64'(occupancy), 64'd2);
    check("err_sticky", 64'(err), 64'd1);

    // Mid-operation reset with 6 occupied and a pending issue
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 32'hB0 + i; tick();
    end
    in_valid = 1'b0;
    check("pre_rst_occ", 64'(occupancy), 64'd6);
    rdy_valid = 1'b1; rdy_index = 4'd0; push(32'hB0, 4'd0);
    tick();
    rdy_valid = 1'b0;
    tick();
    check("pre_rst_issue", 64'(issue_valid), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_issue", 64'(issue_valid), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_alloc", 64'(alloc_index), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
